mcga_prefetch_fifo: RTL and testbench

Sequential read prefetcher between the MCGA scan-out logic and the MCGA master port of the memory arbiter. It issues single-word reads over the 19-bit word-addressed memory bus, starting from a programmed base address. Returned words go into a small first-word-fall-through FIFO, which the display pipeline drains at its own pace. One bus transaction is outstanding at most. A request is issued only when a FIFO slot is guaranteed free.

---
 rtl/mcga_prefetch_fifo.sv | 146 ++++++++++++++
 tb/tb_mcga_prefetch_fifo.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mcga_prefetch_fifo.sv
// Sequential read prefetcher for MCGA scan-out: issues single-word reads from a
// programmed base address and buffers the returned words in a small FWFT FIFO.
module mcga_prefetch_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [18:0]              base_addr,
    input  logic [9:0]               word_count,
    output logic                     busy,
    output logic [18:0]              m_addr,
    input  logic [15:0]              m_data_in,
    output logic                     m_access,
    input  logic                     m_ack,
    output logic                     m_wr_en,
    output logic [1:0]               m_bytesel,
    input  logic                     pop,
    output logic [15:0]              data_out,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;
    localparam logic [1:0] ABORT = 2'd3;

    logic [1:0]    r_state;
    logic [18:0]   r_addr;
    logic [9:0]    r_remaining;
    logic [18:0]   r_pend_addr;
    logic [9:0]    r_pend_count;
    logic [15:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_level;
    logic          r_underflow;

    logic          w_idleOrGap;
    logic          w_abortDone;
    logic          w_flush;
    logic          w_write;
    logic          w_empty;
    logic          w_popOk;
    logic [18:0]   w_newAddr;
    logic [9:0]    w_newCount;

    assign w_idleOrGap = (r_state == IDLE) || (r_state == GAP);
    // A start colliding with an ack in REQ behaves exactly like an abort completing.
    assign w_abortDone = m_ack && ((r_state == ABORT) || ((r_state == REQ) && start));
    assign w_flush     = (w_idleOrGap && start) || w_abortDone;
    assign w_write     = (r_state == REQ) && m_ack && !start;
    assign w_empty     = (r_level == '0);
    assign w_popOk     = pop && !w_empty && !w_flush;
    assign w_newAddr   = start ? base_addr  : r_pend_addr;
    assign w_newCount  = start ? word_count : r_pend_count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_remaining  <= '0;
            r_pend_addr  <= '0;
            r_pend_count <= '0;
        end else begin
            case (r_state)
                IDLE, GAP: begin
                    if (start) begin
                        r_addr      <= base_addr;
                        r_remaining <= word_count;
                        r_state     <= (word_count != '0) ? REQ : IDLE;
                    end else if ((r_state == GAP) && (r_remaining != '0) && (r_level < FULL)) begin
                        r_state <= REQ;
                    end
                end
                REQ: begin
                    if (w_abortDone) begin
                        r_addr      <= w_newAddr;
                        r_remaining <= w_newCount;
                        r_state     <= (w_newCount != '0) ? REQ : IDLE;
                    end else if (start) begin
                        r_pend_addr  <= base_addr;
                        r_pend_count <= word_count;
                        r_state      <= ABORT;
                    end else if (m_ack) begin
                        r_addr      <= r_addr + 19'd1;
                        r_remaining <= r_remaining - 10'd1;
                        r_state     <= (r_remaining == 10'd1) ? IDLE : GAP;
                    end
                end
                default: begin
                    if (w_abortDone) begin
                        r_addr      <= w_newAddr;
                        r_remaining <= w_newCount;
                        r_state     <= (w_newCount != '0) ? REQ : IDLE;
                    end else if (start) begin
                        r_pend_addr  <= base_addr;
                        r_pend_count <= word_count;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_level     <= '0;
            r_underflow <= 1'b0;
        end else begin
            if (w_flush) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_level <= '0;
            end else begin
                if (w_write) r_wptr <= r_wptr + AW'(1);
                if (w_popOk) r_rptr <= r_rptr + AW'(1);
                if (w_write && !w_popOk)      r_level <= r_level + (AW+1)'(1);
                else if (!w_write && w_popOk) r_level <= r_level - (AW+1)'(1);
            end
            if (start)                          r_underflow <= 1'b0;
            else if (pop && w_empty && !w_flush) r_underflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_write) r_mem[r_wptr] <= m_data_in;
    end

    assign m_access  = (r_state == REQ) || (r_state == ABORT);
    assign m_addr    = r_addr;
    assign m_wr_en   = 1'b0;
    assign m_bytesel = 2'b11;
    assign busy      = (r_state != IDLE);
    assign data_out  = w_empty ? 16'h0000 : r_mem[r_rptr];
    assign empty     = w_empty;
    assign level     = r_level;
    assign underflow = r_underflow;

endmodule

// File: tb/tb_mcga_prefetch_fifo.sv
// Directed self-checking bench for mcga_prefetch_fifo: basic run, backpressure,
// address wrap, abort, underflow / zero count and mid-transaction reset.
module tb_mcga_prefetch_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [18:0] base_addr;
    logic [9:0]  word_count;
    logic        busy;
    logic [18:0] m_addr;
    logic [15:0] m_data_in;
    logic        m_access;
    logic        m_ack;
    logic        m_wr_en;
    logic [1:0]  m_bytesel;
    logic        pop;
    logic [15:0] data_out;
    logic        empty;
    logic [3:0]  level;
    logic        underflow;

    int          passCount = 0;
    int          totalCount = 0;
    int          nAcks;
    logic [18:0] addrLog[$];
    logic        busyAfterAck;
    logic        accessAfterAck;

    mcga_prefetch_fifo #(.DEPTH(8)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .word_count(word_count), .busy(busy), .m_addr(m_addr),
        .m_data_in(m_data_in), .m_access(m_access), .m_ack(m_ack),
        .m_wr_en(m_wr_en), .m_bytesel(m_bytesel), .pop(pop),
        .data_out(data_out), .empty(empty), .level(level), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic applyStimulus(input logic [18:0] base, input logic [9:0] count);
        start      = 1'b1;
        base_addr  = base;
        word_count = count;
        tick();
        start = 1'b0;
    endtask

    task automatic popOnce();
        pop = 1'b1;
        tick();
        pop = 1'b0;
    endtask

    // Memory model: acks two cycles after a request is first seen, logs the address.
    task automatic memCycles(input int cycles, input logic [15:0] dataBase);
        int waitCnt = 0;
        int lastAck = -10;
        for (int i = 0; i < cycles; i++) begin
            m_ack = 1'b0;
            if (i == lastAck + 1) begin
                busyAfterAck   = busy;
                accessAfterAck = m_access;
            end
            if (m_access) begin
                waitCnt++;
                if (waitCnt == 3) begin
                    m_ack     = 1'b1;
                    m_data_in = dataBase + 16'(nAcks);
                    addrLog.push_back(m_addr);
                    nAcks++;
                    lastAck = i;
                    waitCnt = 0;
                end
            end else begin
                waitCnt = 0;
            end
            tick();
        end
        m_ack = 1'b0;
    endtask

    function automatic logic [18:0] logAt(input int idx);
        return (idx < addrLog.size()) ? addrLog[idx] : 19'bx;
    endfunction

    task automatic clearLog();
        nAcks = 0;
        addrLog.delete();
    endtask

    initial begin
        int accessSeen;
        reset = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
        m_data_in = '0; m_ack = 1'b0; pop = 1'b0;
        busyAfterAck = 1'bx; accessAfterAck = 1'bx;
        clearLog();
        tick(); tick();

        checkOutput("rst_access", 32'(m_access), 0);
        checkOutput("rst_addr", 32'(m_addr), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_empty", 32'(empty), 1);
        checkOutput("rst_level", 32'(level), 0);
        checkOutput("rst_data", 32'(data_out), 0);
        checkOutput("rst_underflow", 32'(underflow), 0);
        checkOutput("wr_en", 32'(m_wr_en), 0);
        checkOutput("bytesel", 32'(m_bytesel), 3);
        reset = 1'b1;
        tick();

        // Basic run
        applyStimulus(19'h00100, 10'd4);
        checkOutput("basic_first_access", 32'(m_access), 1);
        checkOutput("basic_first_addr", 32'(m_addr), 32'h100);
        memCycles(30, 16'hA000);
        checkOutput("basic_reads", 32'(nAcks), 4);
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("basic_addr%0d", i), 32'(logAt(i)), 32'h100 + 32'(i));
        checkOutput("basic_busy_fall", 32'(busyAfterAck), 0);
        checkOutput("basic_access_fall", 32'(accessAfterAck), 0);
        checkOutput("basic_level", 32'(level), 4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("basic_data%0d", i), 32'(data_out), 32'hA000 + 32'(i));
            popOnce();
        end
        checkOutput("basic_drained_empty", 32'(empty), 1);
        checkOutput("basic_drained_data", 32'(data_out), 0);

        // Backpressure
        clearLog();
        applyStimulus(19'h01000, 10'd12);
        memCycles(60, 16'hA000);
        checkOutput("bp_reads", 32'(nAcks), 8);
        checkOutput("bp_level_full", 32'(level), 8);
        checkOutput("bp_access_low", 32'(m_access), 0);
        checkOutput("bp_busy", 32'(busy), 1);
        popOnce();
        checkOutput("bp_level_after_pop", 32'(level), 7);
        memCycles(20, 16'hA000);
        checkOutput("bp_one_more_read", 32'(nAcks), 9);
        checkOutput("bp_ninth_addr", 32'(logAt(8)), 32'h1008);
        checkOutput("bp_level_refill", 32'(level), 8);
        checkOutput("bp_head", 32'(data_out), 32'hA001);

        // Address wrap
        clearLog();
        applyStimulus(19'h7FFFE, 10'd3);
        memCycles(20, 16'hB000);
        checkOutput("wrap_reads", 32'(nAcks), 3);
        checkOutput("wrap_addr0", 32'(logAt(0)), 32'h7FFFE);
        checkOutput("wrap_addr1", 32'(logAt(1)), 32'h7FFFF);
        checkOutput("wrap_addr2", 32'(logAt(2)), 32'h00000);
        checkOutput("wrap_level", 32'(level), 3);
        checkOutput("wrap_head", 32'(data_out), 32'hB000);

        // Abort while a request is open
        clearLog();
        applyStimulus(19'h00200, 10'd5);
        memCycles(6, 16'hC000);
        checkOutput("abort_pre_level", 32'(level), 1);
        applyStimulus(19'h00300, 10'd2);
        checkOutput("abort_access_held", 32'(m_access), 1);
        checkOutput("abort_addr_held", 32'(m_addr), 32'h201);
        checkOutput("abort_level_kept", 32'(level), 1);
        tick(); tick();
        m_ack = 1'b1; m_data_in = 16'hDEAD;
        tick();
        m_ack = 1'b0;
        checkOutput("abort_flush_empty", 32'(empty), 1);
        checkOutput("abort_flush_level", 32'(level), 0);
        checkOutput("abort_new_addr", 32'(m_addr), 32'h300);
        checkOutput("abort_new_access", 32'(m_access), 1);
        clearLog();
        memCycles(20, 16'hE000);
        checkOutput("abort_reads", 32'(nAcks), 2);
        checkOutput("abort_run_addr1", 32'(logAt(1)), 32'h301);
        checkOutput("abort_level", 32'(level), 2);
        checkOutput("abort_head", 32'(data_out), 32'hE000);
        popOnce();
        checkOutput("abort_second", 32'(data_out), 32'hE001);
        popOnce();

        // Underflow and zero count
        checkOutput("uf_pre", 32'(underflow), 0);
        popOnce();
        checkOutput("uf_set", 32'(underflow), 1);
        checkOutput("uf_level", 32'(level), 0);
        checkOutput("uf_empty", 32'(empty), 1);
        applyStimulus(19'h00400, 10'd0);
        checkOutput("zero_uf_clear", 32'(underflow), 0);
        checkOutput("zero_busy", 32'(busy), 0);
        accessSeen = 0;
        for (int i = 0; i < 5; i++) begin
            if (m_access || busy) accessSeen++;
            tick();
        end
        checkOutput("zero_no_access", 32'(accessSeen), 0);

        // Reset in the middle of a transaction
        clearLog();
        applyStimulus(19'h00500, 10'd3);
        memCycles(5, 16'hF000);
        checkOutput("rst2_pre_level", 32'(level), 1);
        checkOutput("rst2_pre_access", 32'(m_access), 1);
        reset = 1'b0;
        tick();
        checkOutput("rst2_access", 32'(m_access), 0);
        checkOutput("rst2_empty", 32'(empty), 1);
        checkOutput("rst2_level", 32'(level), 0);
        checkOutput("rst2_busy", 32'(busy), 0);
        checkOutput("rst2_addr", 32'(m_addr), 0);
        reset = 1'b1;
        tick();

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
